// File: rtl/pipearch_common_pkg.sv
//==============================================================================
// pipearch_common_pkg: shared state encoding, command record and helpers.
// Rev 1.0
//==============================================================================
`default_nettype none

package pipearch_common_pkg;

    localparam int CMD_ADDR_MAX_W = 64;
    localparam int CMD_LEN_MAX_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_STREAM = 2'd2
    } arb_state_t;

    // Sized for the widest supported bus; users cast to their own widths.
    typedef struct packed {
        logic [CMD_ADDR_MAX_W-1:0] addr;
        logic [CMD_LEN_MAX_W-1:0]  len;
    } dma_cmd_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_read_arbiter_if.sv
//==============================================================================
// dma_read_arbiter_if: requester-side and DMA-engine-side handshake bundle.
// Rev 1.0
//==============================================================================
`default_nettype none

interface dma_read_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 42,
    parameter int LEN_W   = 32,
    parameter int DATA_W  = 512
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [DATA_W-1:0]         rsp_data;
    logic                      dma_cmd_valid;
    logic                      dma_cmd_ready;
    logic [ADDR_W-1:0]         dma_cmd_addr;
    logic [LEN_W-1:0]          dma_cmd_len;
    logic                      dma_rsp_valid;
    logic                      dma_rsp_ready;
    logic [DATA_W-1:0]         dma_rsp_data;

    modport slave (
        input  req_valid, req_addr, req_len, rsp_ready,
        input  dma_cmd_ready, dma_rsp_valid, dma_rsp_data,
        output req_ready, rsp_valid, rsp_data,
        output dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_rsp_ready
    );

    modport master (
        output req_valid, req_addr, req_len, rsp_ready,
        output dma_cmd_ready, dma_rsp_valid, dma_rsp_data,
        input  req_ready, rsp_valid, rsp_data,
        input  dma_cmd_valid, dma_cmd_addr, dma_cmd_len, dma_rsp_ready
    );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
//==============================================================================
// rr_arbiter: combinational round-robin pick, searching from last_grant+1.
// Rev 1.0
//==============================================================================
`default_nettype none

module rr_arbiter
    import pipearch_common_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant
);

    logic             w_found;
    logic [IDX_W-1:0] w_pos;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_pos   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_pos = IDX_W'((int'(last_grant) + off) % NUM_REQ);
            if (!w_found && req[w_pos]) begin
                grant[w_pos] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dma_read_arbiter.sv
//==============================================================================
// dma_read_arbiter: shares one in-order DMA read channel among NUM_REQ users.
// Rev 1.0
//==============================================================================
`default_nettype none

module dma_read_arbiter
    import pipearch_common_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 42,
    parameter int LEN_W   = 32,
    parameter int DATA_W  = 512,
    parameter int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic              clk,
    input  logic              reset,
    dma_read_arbiter_if.slave bus,
    output logic              busy,
    output logic [IDX_W-1:0]  grant_idx
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   r_grant;
    logic [LEN_W-1:0]   r_count;
    dma_cmd_t           r_cmd;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDX_W-1:0]   w_win_idx;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [LEN_W-1:0]   w_sel_len;
    logic [LEN_W-1:0]   w_cmd_len;
    logic               w_accept;
    logic               w_stream;
    logic               w_line_hs;
    logic               w_last_line;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req        (bus.req_valid),
        .last_grant (r_last),
        .grant      (w_gnt)
    );

    always_comb begin
        w_win_idx  = '0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
                w_win_idx  = IDX_W'(i);
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_len  = bus.req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign w_cmd_len   = LEN_W'(r_cmd.len);
    assign w_accept    = (r_state == ST_IDLE) && (|w_gnt);
    assign w_stream    = (r_state == ST_STREAM) && !reset;
    assign w_line_hs   = w_stream && bus.dma_rsp_valid && bus.dma_rsp_ready;
    assign w_last_line = (r_count == (w_cmd_len - LEN_W'(1)));

    // Outputs are forced low during reset even on the first reset cycle,
    // before the state register has had a chance to return to IDLE.
    always_comb begin
        bus.req_ready     = (!reset && r_state == ST_IDLE) ? w_gnt : '0;
        bus.dma_cmd_valid = !reset && (r_state == ST_ISSUE);
        bus.dma_cmd_addr  = ADDR_W'(r_cmd.addr);
        bus.dma_cmd_len   = w_cmd_len;
        bus.rsp_valid     = '0;
        if (w_stream) begin
            bus.rsp_valid[r_grant] = bus.dma_rsp_valid;
        end
        bus.dma_rsp_ready = w_stream && bus.rsp_ready[r_grant];
        bus.rsp_data      = bus.dma_rsp_data;
        busy              = !reset && (r_state != ST_IDLE);
        grant_idx         = r_grant;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_grant <= '0;
            r_count <= '0;
            r_cmd   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_sel_len == '0) begin
                            r_last <= w_win_idx;
                        end else begin
                            r_grant    <= w_win_idx;
                            r_cmd.addr <= CMD_ADDR_MAX_W'(w_sel_addr);
                            r_cmd.len  <= CMD_LEN_MAX_W'(w_sel_len);
                            r_state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.dma_cmd_ready) begin
                        r_state <= ST_STREAM;
                        r_count <= '0;
                    end
                end
                ST_STREAM: begin
                    if (w_line_hs) begin
                        r_count <= r_count + 1'b1;
                        if (w_last_line) begin
                            r_state <= ST_IDLE;
                            r_last  <= r_grant;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dma_read_arbiter.md
DMA_READ_ARBITER -- requirements
Module: dma_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing one DMA read channel.
REQ-002 Parameter ADDR_W, default 42: cache-line address width.
REQ-003 Parameter LEN_W, default 32: transfer length width, in cache lines.
REQ-004 Parameter DATA_W, default 512: cache-line data width.
REQ-005 Port clk  in  1: single clock for all logic.
REQ-006 Port reset  in  1: synchronous, active-high reset.
REQ-007 Port req_valid  in  NUM_REQ: per-requester transfer request.
REQ-008 Port req_ready  out  NUM_REQ: per-requester request accept.
REQ-009 Port req_addr  in  NUM_REQ*ADDR_W: per-requester start line address.
REQ-010 Port req_len  in  NUM_REQ*LEN_W: per-requester length, in lines.
REQ-011 Port rsp_valid  out  NUM_REQ: per-requester response-line strobe.
REQ-012 Port rsp_ready  in  NUM_REQ: per-requester response accept.
REQ-013 Port rsp_data  out  DATA_W: response line, shared by all requesters.
REQ-014 Port dma_cmd_valid / dma_cmd_ready  out / in  1 / 1: command handshake toward the DMA read engine.
REQ-015 Port dma_cmd_addr / dma_cmd_len  out  ADDR_W / LEN_W: command fields.
REQ-016 Port dma_rsp_valid / dma_rsp_ready  in / out  1 / 1: in-order line return handshake from the DMA read engine.
REQ-017 Port dma_rsp_data  in  DATA_W: returned line.
REQ-018 Port busy  out  1: high whenever the state is not IDLE.
REQ-019 Port grant_idx  out  $clog2(NUM_REQ): current owner of the channel.

Function
REQ-020 The FSM SHALL have three states: IDLE, ISSUE and STREAM.
REQ-021 IDLE arbitration: among the asserted req_valid bits, the first one found searching round-robin from last_grant+1 wins; in the same cycle req_ready[winner]=1 and all other req_ready bits are 0.
REQ-022 On acceptance, the block SHALL register the winner's addr and len, set grant_idx to the winner, and go to ISSUE; if len==0, it SHALL instead stay in IDLE, update last_grant, and issue no command.
REQ-023 ISSUE: dma_cmd_valid=1 with the registered addr/len, held stable until dma_cmd_ready; on the handshake, go to STREAM and clear the line counter.
REQ-024 Command latency: a request accepted at cycle N SHALL present dma_cmd_valid at N+1.
REQ-025 STREAM routing: rsp_valid[grant_idx]=dma_rsp_valid; rsp_data=dma_rsp_data; dma_rsp_ready=rsp_ready[grant_idx]; the block is combinational and adds zero latency.
REQ-026 The line counter SHALL increment on each dma_rsp_valid&dma_rsp_ready handshake.
REQ-027 On the handshake where counter==len-1, the block SHALL go to IDLE and set last_grant=grant_idx.
REQ-028 Outside STREAM, dma_rsp_ready=0 and all rsp_valid bits are 0.
REQ-029 No new request SHALL be accepted before the current transfer completes; a request arriving in the completion cycle is arbitrated on the next cycle.
REQ-030 Simultaneous requests with last_grant=k SHALL be granted in the order k+1, k+2, … modulo NUM_REQ.
REQ-031 The counter SHALL be LEN_W bits wide; len=2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-032 While reset is high, the state SHALL be IDLE, last_grant=NUM_REQ-1, counter=0 and grant_idx=0.
REQ-033 While reset is high, all outputs SHALL be 0 (req_ready, rsp_valid, dma_cmd_valid, dma_rsp_ready, busy); rsp_data and dma_cmd fields are don't-care.
REQ-034 A reset asserted mid-transfer SHALL abandon the transfer; requester 0 has first priority after reset.

Structure
REQ-035 The state enum and the {addr,len} command struct SHALL live in pipearch_common_pkg.
REQ-036 Round-robin selection SHALL be a sub-module rr_arbiter (NUM_REQ request vector plus last_grant in; one-hot grant out; combinational).

Verification
REQ-037 Single request: req0 addr=0x100, len=4; cmd_ready=1 → cmd at N+1 with addr 0x100, len 4; 4 lines on rsp_valid[0]; busy falls after the 4th line.
REQ-038 Contention: req0 and req1 both held, len=2 each, from reset → grant order 0,1,0,1; no line ever appears on the non-granted rsp_valid.
REQ-039 Backpressure: rsp_ready[1] toggles every cycle during a len=8 transfer → dma_rsp_ready mirrors it; exactly 8 handshakes; data order preserved.
REQ-040 Zero length: req1 len=0 → req_ready pulse, no dma_cmd_valid, busy stays 0, last_grant=1.
REQ-041 Cmd stall: dma_cmd_ready=0 for 5 cycles → dma_cmd_valid, addr and len held stable throughout, then STREAM.
REQ-042 Reset mid-STREAM after 3 of 6 lines → next cycle all outputs 0, state IDLE; a new req0 is accepted normally.
